// File: rtl/display_pkg.sv
// Shared digit codes, FSM states and active-low 7-segment patterns ({g,f,e,d,c,b,a})
// for the motor-current display sequencer.
package display_pkg;

    localparam logic [3:0] CODE_R     = 4'hA;
    localparam logic [3:0] CODE_F     = 4'hB;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        COMMIT
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational digit-code to active-low segment pattern lookup.
module sevenseg_decoder
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            CODE_R:  seg = SEG_R;
            CODE_F:  seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan_sequencer.sv
// Samples motor current periodically, converts it to BCD with a serial double-dabble
// engine, and multiplexes direction symbol plus three digits onto the 4-digit display.
module display_scan_sequencer
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 65536,
    parameter int SAMPLE_DIV  = 10_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SW7,
    input  logic [15:0] current_num,
    input  logic        blank,
    output logic [6:0]  SEG,
    output logic [3:0]  AN,
    output logic        busy,
    output logic        overflow
);

    localparam int SW = $clog2(SAMPLE_DIV + 1);
    localparam int RW = $clog2(REFRESH_DIV + 1);

    generate
        if (SAMPLE_DIV < 20) begin : g_sample_div_check
            $error("SAMPLE_DIV must be at least 20 so a tick cannot land mid-conversion");
        end
    endgenerate

    logic          sw7_meta, sw7_sync;
    logic [SW-1:0] sample_cnt;
    logic          sample_tick;
    scan_state_t   state, state_next;
    logic [3:0]    shift_cnt;
    logic [15:0]   bin_sr;
    logic [19:0]   bcd_sr;
    logic          dir_bit;
    logic [3:0]    dir_code, hund_code, tens_code, unit_code;
    logic          shown;
    logic [RW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    scan_code;
    logic [6:0]    seg_next;

    function automatic logic [19:0] bcd_add3(input logic [19:0] bcd);
        logic [19:0] r;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return r;
    endfunction

    // Saturates to 999 above three digits, otherwise blanks leading zeros.
    function automatic logic [11:0] commit_digits(input logic [19:0] bcd);
        logic [3:0] h, t, u;
        h = bcd[11:8];
        t = bcd[7:4];
        u = bcd[3:0];
        if (bcd[19:12] != 8'd0) begin
            return {4'd9, 4'd9, 4'd9};
        end
        return {(h == 4'd0) ? CODE_BLANK : h,
                (h == 4'd0 && t == 4'd0) ? CODE_BLANK : t,
                u};
    endfunction

    assign sample_tick = (sample_cnt == SW'(SAMPLE_DIV - 1));
    assign busy        = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_tick) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (shift_cnt == 4'd15) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sw7_meta    <= 1'b0;
            sw7_sync    <= 1'b0;
            sample_cnt  <= '0;
            shift_cnt   <= 4'd0;
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            dir_code    <= CODE_BLANK;
            hund_code   <= CODE_BLANK;
            tens_code   <= CODE_BLANK;
            unit_code   <= CODE_BLANK;
            shown       <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state    <= state_next;
            sw7_meta <= SW7;
            sw7_sync <= sw7_meta;
            sample_cnt <= sample_tick ? '0 : sample_cnt + SW'(1);
            if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
            if (state == LOAD)  shift_cnt <= 4'd0;
            if (state == SHIFT) shift_cnt <= shift_cnt + 4'd1;
            if (state == COMMIT) begin
                {hund_code, tens_code, unit_code} <= commit_digits(bcd_sr);
                overflow <= (bcd_sr[19:12] != 8'd0);
                dir_code <= dir_bit ? CODE_R : CODE_F;
                shown    <= 1'b1;
            end
        end
    end

    // Conversion datapath: loaded once per sample, shifted 16 times.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            bin_sr  <= current_num;
            bcd_sr  <= 20'd0;
            dir_bit <= sw7_sync;
        end else if (state == SHIFT) begin
            {bcd_sr, bin_sr} <= {bcd_add3(bcd_sr), bin_sr} << 1;
        end
    end

    always_comb begin
        scan_code = CODE_BLANK;
        case (digit_idx)
            2'd0: scan_code = dir_code;
            2'd1: scan_code = hund_code;
            2'd2: scan_code = tens_code;
            2'd3: scan_code = unit_code;
            default: scan_code = CODE_BLANK;
        endcase
    end

    sevenseg_decoder u_decoder (
        .code (scan_code),
        .seg  (seg_next)
    );

    // Output stage: display stays dark until something has been committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SEG <= SEG_BLANK;
            AN  <= 4'b1111;
        end else begin
            SEG <= seg_next;
            AN  <= (blank || !shown) ? 4'b1111 : ~(4'b1000 >> digit_idx);
        end
    end

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Randomized self-checking bench for display_scan_sequencer with a decimal reference model.
module tb_display_scan_sequencer;

    localparam int REFRESH_DIV = 4;
    localparam int SAMPLE_DIV  = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        SW7;
    logic [15:0] current_num;
    logic        blank;
    logic [6:0]  SEG;
    logic [3:0]  AN;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    display_scan_sequencer #(
        .REFRESH_DIV (REFRESH_DIV),
        .SAMPLE_DIV  (SAMPLE_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .SW7         (SW7),
        .current_num (current_num),
        .blank       (blank),
        .SEG         (SEG),
        .AN          (AN),
        .busy        (busy),
        .overflow    (overflow)
    );

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Slot 0 = AN 0111 (direction), 1 = hundreds, 2 = tens, 3 = units.
    function automatic logic [3:0][6:0] expected_scan(int n, bit dir);
        logic [3:0][6:0] r;
        int h, t, u;
        if (n > 999) begin
            h = 9; t = 9; u = 9;
        end else begin
            h = n / 100; t = (n / 10) % 10; u = n % 10;
        end
        r[0] = dir ? 7'b0101111 : 7'b0001110;
        r[1] = (n <= 999 && h == 0) ? 7'b1111111 : seg_of(h);
        r[2] = (n <= 999 && h == 0 && t == 0) ? 7'b1111111 : seg_of(t);
        r[3] = seg_of(u);
        return r;
    endfunction

    task automatic wait_busy_rise(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_busy(input int start, output int cycles, output bit ok);
        cycles = start;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            cycles++;
        end
    endtask

    task automatic capture_scan(output logic [3:0][6:0] segs, output logic [3:0] seen);
        segs = '1;
        seen = 4'b0000;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            case (AN)
                4'b0111: begin segs[0] = SEG; seen[0] = 1'b1; end
                4'b1011: begin segs[1] = SEG; seen[1] = 1'b1; end
                4'b1101: begin segs[2] = SEG; seen[2] = 1'b1; end
                4'b1110: begin segs[3] = SEG; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic run_conversion(input int n, input bit dir, output int bcycles, output bit ok,
                                  output logic [3:0][6:0] segs, output logic [3:0] seen);
        bit ok_rise, ok_fall;
        current_num = 16'(n);
        SW7 = dir;
        wait_busy_rise(ok_rise);
        bcycles = 0;
        ok_fall = 1'b0;
        if (ok_rise) count_busy(1, bcycles, ok_fall);
        ok = ok_rise && ok_fall;
        capture_scan(segs, seen);
    endtask

    task automatic test_reset();
        bit dark_ok;
        rst_n = 1'b0; SW7 = 1'b0; blank = 1'b0; current_num = 16'd305;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++; if (AN !== 4'b1111) begin n_fail++; $display("FAIL reset_an: AN=%b required 1111", AN); end
        n_checks++; if (SEG !== 7'b1111111) begin n_fail++; $display("FAIL reset_seg: SEG=%b required 1111111", SEG); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: busy=%b required 0", busy); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: overflow=%b required 0", overflow); end
        rst_n = 1'b1;
        dark_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (AN !== 4'b1111 || busy !== 1'b0) dark_ok = 1'b0;
        end
        n_checks++; if (!dark_ok) begin n_fail++; $display("FAIL dark_before_commit: AN=%b busy=%b required AN 1111 busy 0", AN, busy); end
    endtask

    task automatic check_conversion(input string name, input int n, input bit dir);
        int bc; bit ok;
        logic [3:0][6:0] segs, exp;
        logic [3:0] seen;
        run_conversion(n, dir, bc, ok, segs, seen);
        exp = expected_scan(n, dir);
        n_checks++; if (!ok || bc != 18) begin n_fail++; $display("FAIL %s_busy_len: busy cycles=%0d (done=%0d) required 18", name, bc, ok); end
        n_checks++; if (overflow !== (n > 999)) begin n_fail++; $display("FAIL %s_overflow: overflow=%b required %0d", name, overflow, n > 999); end
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (seen[s] !== 1'b1 || segs[s] !== exp[s]) begin
                n_fail++;
                $display("FAIL %s_slot%0d: n=%0d SEG=%b seen=%b required %b", name, s, n, segs[s], seen[s], exp[s]);
            end
        end
    endtask

    task automatic test_basic();
        check_conversion("basic305", 305, 1'b0);
    endtask

    task automatic test_small_backward();
        check_conversion("small7", 7, 1'b1);
    endtask

    task automatic test_overflow();
        check_conversion("ovf65535", 65535, 1'b0);
        check_conversion("after_ovf42", 42, 1'b0);
    endtask

    task automatic test_hold_and_drop();
        bit ok_rise, ok_fall, quiet;
        int bc;
        logic [3:0][6:0] segs, exp;
        logic [3:0] seen;
        current_num = 16'd123; SW7 = 1'b0;
        wait_busy_rise(ok_rise);
        repeat (3) @(negedge clk);
        current_num = 16'd456;
        force dut.sample_tick = 1'b1;
        @(negedge clk);
        release dut.sample_tick;
        bc = 0; ok_fall = 1'b0;
        if (ok_rise) count_busy(5, bc, ok_fall);
        n_checks++; if (!(ok_rise && ok_fall) || bc != 18) begin n_fail++; $display("FAIL drop_busy_len: busy cycles=%0d required 18", bc); end
        quiet = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) quiet = 1'b0;
        end
        n_checks++; if (!quiet) begin n_fail++; $display("FAIL drop_no_requeue: busy=1 seen required 0"); end
        capture_scan(segs, seen);
        exp = expected_scan(123, 1'b0);
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (seen[s] !== 1'b1 || segs[s] !== exp[s]) begin
                n_fail++;
                $display("FAIL hold123_slot%0d: SEG=%b seen=%b required %b", s, segs[s], seen[s], exp[s]);
            end
        end
        check_conversion("next456", 456, 1'b0);
    endtask

    task automatic test_random();
        int n; bit dir;
        for (int k = 0; k < 6; k++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1200));
            dir = 1'($urandom_range(0, 1));
            check_conversion("random", n, dir);
        end
    endtask

    task automatic test_blank_and_reset();
        bit ok_rise, dark_ok;
        check_conversion("pre_blank", 1000, 1'b1);
        @(negedge clk);
        blank = 1'b1;
        @(negedge clk);
        n_checks++; if (AN !== 4'b1111) begin n_fail++; $display("FAIL blank_next_clock: AN=%b required 1111", AN); end
        dark_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (AN !== 4'b1111) dark_ok = 1'b0;
        end
        n_checks++; if (!dark_ok) begin n_fail++; $display("FAIL blank_held: AN=%b required 1111", AN); end
        blank = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (AN === 4'b1111) begin n_fail++; $display("FAIL unblank: AN=%b required a lit digit", AN); end
        wait_busy_rise(ok_rise);
        n_checks++; if (!ok_rise) begin n_fail++; $display("FAIL reset_mid_wait: busy=%b required 1 within bound", busy); end
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: busy=%b required 0", busy); end
        n_checks++; if (AN !== 4'b1111) begin n_fail++; $display("FAIL midreset_an: AN=%b required 1111", AN); end
        n_checks++; if (SEG !== 7'b1111111) begin n_fail++; $display("FAIL midreset_seg: SEG=%b required 1111111", SEG); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL midreset_ovf: overflow=%b required 0", overflow); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dark_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (AN !== 4'b1111 || busy !== 1'b0) dark_ok = 1'b0;
        end
        n_checks++; if (!dark_ok) begin n_fail++; $display("FAIL post_reset_dark: AN=%b busy=%b required 1111/0", AN, busy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small_backward();
        test_overflow();
        test_hold_and_drop();
        test_random();
        test_blank_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
